// File: rtl/lfsr_pkg.sv
// Shared types and constants for the shared-LFSR controller: FSM states,
// legal width range and the XNOR feedback tap mask per width.
package lfsr_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_RESEED = 1'b1
  } state_t;

  localparam int N_MIN = 3;
  localparam int N_MAX = 10;

  // Bit i set means lfsr[i] feeds the XNOR chain.
  function automatic logic [N_MAX-1:0] tap_mask(input int n);
    logic [N_MAX-1:0] m;
    case (n)
      3:       m = 10'b00_0000_0110;
      4:       m = 10'b00_0000_1100;
      5:       m = 10'b00_0001_0100;
      6:       m = 10'b00_0011_0000;
      7:       m = 10'b00_0110_0000;
      8:       m = 10'b00_1011_1000;
      9:       m = 10'b01_0001_0000;
      10:      m = 10'b10_0100_0000;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_step_en.sv
// N-bit XNOR Fibonacci LFSR: shifts left with feedback into bit 0 when en is
// high; load takes priority and replaces the register with load_val.
module lfsr_step_en
  import lfsr_pkg::*;
#(
  parameter int             N    = 8,
  parameter logic [N-1:0]   SEED = N'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q
);

  localparam logic [N_MAX-1:0] MASK_ALL = tap_mask(N);
  localparam logic [N-1:0]     MASK     = MASK_ALL[N-1:0];

  logic         fb;
  logic [N-1:0] q_nxt;

  assign fb    = ~(^(q & MASK));
  assign q_nxt = {q[N-2:0], fb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Round-robin sharing of one XNOR LFSR among REQ requesters, with runtime
// reseeding and lock-up seed rejection. Optional wrap pulse: LFSR_WRAP_DET_EN.
//
//   state     | meaning
//   ST_RUN    | arbitrate requests; seed_load moves to ST_RESEED
//   ST_RESEED | one-cycle busy slot after a seed load, no grants
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int           N    = 8,
  parameter int           REQ  = 4,
  parameter logic [N-1:0] SEED = N'(1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [REQ-1:0] req,
  output logic [REQ-1:0] gnt,
  output logic [N-1:0]   num,
  input  logic           seed_load,
  input  logic [N-1:0]   seed,
  output logic           seed_err,
  output logic           busy
`ifdef LFSR_WRAP_DET_EN
  ,
  output logic           wrap
`endif
);

  localparam int PW  = $clog2(REQ);
  localparam int PW1 = PW + 1;

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("lfsr_share_ctrl: N out of range 3..10");
  end
  if (REQ < 2 || REQ > 8) begin : g_bad_req
    $error("lfsr_share_ctrl: REQ out of range 2..8");
  end
  if (SEED == {N{1'b1}}) begin : g_bad_seed
    $error("lfsr_share_ctrl: SEED must not be all ones");
  end

  state_t         state, state_nxt;
  logic [PW-1:0]  rr_ptr, ptr_nxt, win;
  logic [PW:0]    cand;
  logic [REQ-1:0] eligible, gnt_nxt;
  logic           hit, grant_en, load_en, seed_all1;
  logic [N-1:0]   lfsr_q, load_val;

  assign eligible  = req & ~gnt;
  assign seed_all1 = (seed == {N{1'b1}});
  assign load_val  = seed_all1 ? N'(1) : seed;
  assign busy      = (state == ST_RESEED);

  // First eligible index at or above rr_ptr, wrapping modulo REQ.
  always_comb begin
    hit  = 1'b0;
    win  = '0;
    cand = '0;
    for (int i = 0; i < REQ; i++) begin
      cand = {1'b0, rr_ptr} + PW1'(i);
      if (cand >= PW1'(REQ)) cand = cand - PW1'(REQ);
      if (!hit && eligible[cand[PW-1:0]]) begin
        hit = 1'b1;
        win = cand[PW-1:0];
      end
    end
  end

  assign gnt_nxt = REQ'(1) << win;
  assign ptr_nxt = (win == PW'(REQ - 1)) ? '0 : win + PW'(1);

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    load_en   = 1'b0;
    case (state)
      ST_RUN: begin
        if (seed_load) begin
          load_en   = 1'b1;
          state_nxt = ST_RESEED;
        end else if (hit) begin
          grant_en = 1'b1;
        end
      end
      ST_RESEED: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      gnt      <= '0;
      num      <= '0;
      rr_ptr   <= '0;
      seed_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= grant_en ? gnt_nxt : '0;
      seed_err <= load_en & seed_all1;
      if (grant_en) begin
        num    <= lfsr_q;
        rr_ptr <= ptr_nxt;
      end
    end
  end

  lfsr_step_en #(
    .N    (N),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (grant_en),
    .load     (load_en),
    .load_val (load_val),
    .q        (lfsr_q)
  );

`ifdef LFSR_WRAP_DET_EN
  // A maximal-length sequence revisits the seed after 2^N-1 steps.
  localparam logic [N-1:0] WRAP_AT = N'((2 ** N) - 2);
  logic [N-1:0] step_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      wrap     <= 1'b0;
    end else if (load_en) begin
      step_cnt <= '0;
      wrap     <= 1'b0;
    end else if (grant_en) begin
      if (step_cnt == WRAP_AT) begin
        step_cnt <= '0;
        wrap     <= 1'b1;
      end else begin
        step_cnt <= step_cnt + N'(1);
        wrap     <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end
`endif

endmodule
